// File: rtl/music_scheduler.sv
// Audio playback sequencer: shares one note-lookup path between a looping BGM
// stream and NUM_SFX one-shot sound effects, with beat divider and pause.
module music_scheduler #(
    parameter int BGM_LEN  = 128,
    parameter int SFX_LEN  = 32,
    parameter int NUM_SFX  = 4,
    parameter int TICK_DIV = 12500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_en,
    input  logic               pause,
    input  logic [1:0]         bgm_sel,
    input  logic [NUM_SFX-1:0] sfx_req,
    output logic               beat_tick,
    output logic [11:0]        ibeat,
    output logic [2:0]         track_id,
    output logic               mute,
    output logic               sfx_busy,
    output logic               sfx_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, BGM = 2'd1, SFX = 2'd2} state_t;

    localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);
    localparam logic [11:0] BGM_LAST = 12'(BGM_LEN - 1);
    localparam logic [11:0] SFX_LAST = 12'(SFX_LEN - 1);

    state_t             state_r, state_s;
    logic [31:0]        div_r, div_s;
    logic [11:0]        ibeat_r, ibeat_s, saved_r, saved_s;
    logic [2:0]         track_r, track_s;
    logic [1:0]         sel_r, sel_s;
    logic [NUM_SFX-1:0] pend_r, req_q_r, clr_s;
    logic               tick_r, done_r;
    logic               run_s, wrap_s, last_s, have_s, start_s;
    logic [1:0]         pick_s;

    function automatic logic [1:0] lowest(input logic [NUM_SFX-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            idx = v[i] ? 2'(i) : idx;
        end
        return idx;
    endfunction

    // Next-state, divider and beat-index computation; pause holds everything.
    always_comb begin
        run_s   = (state_r != IDLE) && !pause;
        wrap_s  = run_s && (div_r == DIV_LAST);
        last_s  = wrap_s && (ibeat_r == SFX_LAST);
        have_s  = |pend_r;
        pick_s  = lowest(pend_r);
        start_s = 1'b0;
        state_s = state_r;
        div_s   = div_r;
        ibeat_s = ibeat_r;
        saved_s = saved_r;
        track_s = track_r;
        sel_s   = sel_r;
        if (pause) begin
            state_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    div_s = 32'd0;
                    if (have_s) begin
                        start_s = 1'b1;
                    end else if (play_en) begin
                        state_s = BGM;
                        ibeat_s = 12'd0;
                        sel_s   = bgm_sel;
                        track_s = {1'b0, bgm_sel};
                    end else begin
                        state_s = IDLE;
                    end
                end
                BGM: begin
                    if (have_s) begin
                        start_s = 1'b1;
                        saved_s = ibeat_r;
                    end else if (!play_en) begin
                        state_s = IDLE;
                        div_s   = 32'd0;
                        ibeat_s = 12'd0;
                    end else if (bgm_sel != sel_r) begin
                        div_s   = 32'd0;
                        ibeat_s = 12'd0;
                        sel_s   = bgm_sel;
                        track_s = {1'b0, bgm_sel};
                    end else if (wrap_s) begin
                        div_s   = 32'd0;
                        ibeat_s = (ibeat_r == BGM_LAST) ? 12'd0 : ibeat_r + 12'd1;
                    end else begin
                        div_s = div_r + 32'd1;
                    end
                end
                SFX: begin
                    // Song select is sampled only here, so changes during an effect wait for it.
                    if (last_s) begin
                        if (have_s) begin
                            start_s = 1'b1;
                        end else if (play_en) begin
                            state_s = BGM;
                            div_s   = 32'd0;
                            ibeat_s = saved_r;
                            sel_s   = bgm_sel;
                            track_s = {1'b0, bgm_sel};
                        end else begin
                            state_s = IDLE;
                            div_s   = 32'd0;
                            ibeat_s = 12'd0;
                        end
                    end else if (wrap_s) begin
                        div_s   = 32'd0;
                        ibeat_s = ibeat_r + 12'd1;
                    end else begin
                        div_s = div_r + 32'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    div_s   = 32'd0;
                    ibeat_s = 12'd0;
                end
            endcase
        end
        if (start_s) begin
            state_s = SFX;
            div_s   = 32'd0;
            ibeat_s = 12'd0;
            track_s = 3'd4 + {1'b0, pick_s};
        end else begin
            track_s = track_s;
        end
        for (int i = 0; i < NUM_SFX; i++) begin
            clr_s[i] = start_s && (pick_s == 2'(i));
        end
    end

    // State registers; tick/done are precomputed so they align with the wrap cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            div_r   <= 32'd0;
            ibeat_r <= 12'd0;
            saved_r <= 12'd0;
            track_r <= 3'd0;
            sel_r   <= 2'd0;
            pend_r  <= '0;
            req_q_r <= '0;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            ibeat_r <= ibeat_s;
            saved_r <= saved_s;
            track_r <= track_s;
            sel_r   <= sel_s;
            pend_r  <= (pend_r & ~clr_s) | (sfx_req & ~req_q_r);
            req_q_r <= sfx_req;
            tick_r  <= (state_s != IDLE) && (div_s == DIV_LAST);
            done_r  <= (state_s == SFX) && (div_s == DIV_LAST) && (ibeat_s == SFX_LAST);
        end
    end

    // A held tick/done flag during pause must not leak out until the beat really completes.
    assign beat_tick = tick_r && !pause;
    assign sfx_done  = done_r && !pause;
    assign sfx_busy  = (state_r == SFX);
    assign ibeat     = ibeat_r;
    assign track_id  = track_r;
    assign mute      = (state_r == IDLE) || pause;

endmodule

// File: tb/tb_music_scheduler.sv
// Directed self-checking bench for music_scheduler with TICK_DIV=4, BGM_LEN=8,
// SFX_LEN=3, NUM_SFX=4.
module tb_music_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        play_en;
    logic        pause;
    logic [1:0]  bgm_sel;
    logic [3:0]  sfx_req;
    logic        beat_tick;
    logic [11:0] ibeat;
    logic [2:0]  track_id;
    logic        mute;
    logic        sfx_busy;
    logic        sfx_done;

    int tests = 0;
    int fails = 0;

    music_scheduler #(
        .BGM_LEN (8),
        .SFX_LEN (3),
        .NUM_SFX (4),
        .TICK_DIV(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .play_en  (play_en),
        .pause    (pause),
        .bgm_sel  (bgm_sel),
        .sfx_req  (sfx_req),
        .beat_tick(beat_tick),
        .ibeat    (ibeat),
        .track_id (track_id),
        .mute     (mute),
        .sfx_busy (sfx_busy),
        .sfx_done (sfx_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance pre cycles and expect the tick cycle of beat ib.
    task automatic tick_chk(input int pre, input logic [2:0] tr, input logic [11:0] ib,
                            input logic done, input logic busy);
        repeat (pre) step();
        chk("tick_pulse", 32'(beat_tick), 32'd1);
        chk("tick_track", 32'(track_id), 32'(tr));
        chk("tick_ibeat", 32'(ibeat), 32'(ib));
        chk("tick_done", 32'(sfx_done), 32'(done));
        chk("tick_busy", 32'(sfx_busy), 32'(busy));
        chk("tick_mute", 32'(mute), 32'd0);
    endtask

    // One cycle after a tick: new beat index, no pulses.
    task automatic adv_chk(input logic [2:0] tr, input logic [11:0] ib, input logic busy);
        step();
        chk("adv_tick", 32'(beat_tick), 32'd0);
        chk("adv_done", 32'(sfx_done), 32'd0);
        chk("adv_track", 32'(track_id), 32'(tr));
        chk("adv_ibeat", 32'(ibeat), 32'(ib));
        chk("adv_busy", 32'(sfx_busy), 32'(busy));
    endtask

    // Full 3-beat effect from entry, then check the state it hands over to.
    task automatic run_sfx(input int first_pre, input logic [2:0] tr,
                           input logic [2:0] ntr, input logic [11:0] nib, input logic nbusy);
        for (int i = 0; i < 3; i++) begin
            tick_chk((i == 0) ? first_pre : 3, tr, 12'(i), (i == 2), 1'b1);
            if (i < 2) adv_chk(tr, 12'(i + 1), 1'b1);
            else       adv_chk(ntr, nib, nbusy);
        end
    endtask

    initial begin
        reset = 1'b0; play_en = 1'b0; pause = 1'b0; bgm_sel = 2'd0; sfx_req = 4'd0;
        step(); step();
        chk("rst_ibeat", 32'(ibeat), 32'd0);
        chk("rst_track", 32'(track_id), 32'd0);
        chk("rst_mute", 32'(mute), 32'd1);
        chk("rst_tick", 32'(beat_tick), 32'd0);
        chk("rst_busy", 32'(sfx_busy), 32'd0);
        chk("rst_done", 32'(sfx_done), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_tick", 32'(beat_tick), 32'd0);
            chk("idle_mute", 32'(mute), 32'd1);
            chk("idle_ibeat", 32'(ibeat), 32'd0);
            chk("idle_track", 32'(track_id), 32'd0);
        end

        // BGM song 2, ibeat runs 0..7,0 and on to 5
        play_en = 1'b1; bgm_sel = 2'd2;
        step();
        chk("bgm_entry_track", 32'(track_id), 32'd2);
        chk("bgm_entry_ibeat", 32'(ibeat), 32'd0);
        chk("bgm_entry_mute", 32'(mute), 32'd0);
        chk("bgm_entry_tick", 32'(beat_tick), 32'd0);
        for (int b = 0; b < 13; b++) begin
            tick_chk(3, 3'd2, 12'(b % 8), 1'b0, 1'b0);
            adv_chk(3'd2, 12'((b + 1) % 8), 1'b0);
        end

        // Preempt at ibeat 5 with effect 1, resume at 5
        sfx_req = 4'b0010;
        step();
        sfx_req = 4'b0000;
        step();
        chk("pre_track", 32'(track_id), 32'd5);
        chk("pre_ibeat", 32'(ibeat), 32'd0);
        chk("pre_busy", 32'(sfx_busy), 32'd1);
        run_sfx(3, 3'd5, 3'd2, 12'd5, 1'b0);
        tick_chk(3, 3'd2, 12'd5, 1'b0, 1'b0);
        adv_chk(3'd2, 12'd6, 1'b0);

        // Effect 3, with 2 then 0 requested during it: 3 -> 0 -> 2 -> BGM
        sfx_req = 4'b1000;
        step();
        sfx_req = 4'b0000;
        step();
        chk("q3_track", 32'(track_id), 32'd7);
        chk("q3_ibeat", 32'(ibeat), 32'd0);
        chk("q3_busy", 32'(sfx_busy), 32'd1);
        sfx_req = 4'b0100;
        step();
        sfx_req = 4'b0001;
        step();
        sfx_req = 4'b0000;
        run_sfx(1, 3'd7, 3'd4, 12'd0, 1'b1);
        run_sfx(3, 3'd4, 3'd6, 12'd0, 1'b1);
        run_sfx(3, 3'd6, 3'd2, 12'd6, 1'b0);

        // Pause with divider at 2: frozen 20 cycles, then tick after 1 cycle
        step(); step();
        pause = 1'b1;
        #1;
        chk("pause_mute_now", 32'(mute), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("pause_tick", 32'(beat_tick), 32'd0);
            chk("pause_mute", 32'(mute), 32'd1);
            chk("pause_ibeat", 32'(ibeat), 32'd6);
            chk("pause_track", 32'(track_id), 32'd2);
        end
        pause = 1'b0;
        #1;
        chk("unpause_mute", 32'(mute), 32'd0);
        tick_chk(1, 3'd2, 12'd6, 1'b0, 1'b0);
        adv_chk(3'd2, 12'd7, 1'b0);

        // Request latched during pause starts only after release
        pause = 1'b1;
        sfx_req = 4'b0001;
        step();
        sfx_req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("defer_track", 32'(track_id), 32'd2);
            chk("defer_busy", 32'(sfx_busy), 32'd0);
            chk("defer_ibeat", 32'(ibeat), 32'd7);
            chk("defer_mute", 32'(mute), 32'd1);
            chk("defer_tick", 32'(beat_tick), 32'd0);
        end
        pause = 1'b0;
        step();
        chk("defer_start_track", 32'(track_id), 32'd4);
        chk("defer_start_ibeat", 32'(ibeat), 32'd0);
        chk("defer_start_busy", 32'(sfx_busy), 32'd1);
        chk("defer_start_mute", 32'(mute), 32'd0);

        // Async reset mid-effect with effect 1 pending
        tick_chk(3, 3'd4, 12'd0, 1'b0, 1'b1);
        adv_chk(3'd4, 12'd1, 1'b1);
        sfx_req = 4'b0010;
        step();
        sfx_req = 4'b0000;
        play_en = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("areset_ibeat", 32'(ibeat), 32'd0);
        chk("areset_track", 32'(track_id), 32'd0);
        chk("areset_mute", 32'(mute), 32'd1);
        chk("areset_busy", 32'(sfx_busy), 32'd0);
        chk("areset_tick", 32'(beat_tick), 32'd0);
        chk("areset_done", 32'(sfx_done), 32'd0);
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_busy", 32'(sfx_busy), 32'd0);
            chk("post_rst_mute", 32'(mute), 32'd1);
            chk("post_rst_track", 32'(track_id), 32'd0);
        end
        sfx_req = 4'b0100;
        step();
        sfx_req = 4'b0000;
        play_en = 1'b1;
        step();
        chk("post_rst_sfx_track", 32'(track_id), 32'd6);
        chk("post_rst_sfx_ibeat", 32'(ibeat), 32'd0);
        chk("post_rst_sfx_busy", 32'(sfx_busy), 32'd1);
        run_sfx(3, 3'd6, 3'd2, 12'd0, 1'b0);
        tick_chk(3, 3'd2, 12'd0, 1'b0, 1'b0);
        adv_chk(3'd2, 12'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
